wb_queue: RTL and testbench
===========================

# wb_queue

Write-back queue on the register-file write side of the MIPS datapath. It accepts results from execute/memory stages over a valid/ready handshake and buffers them in an in-order FIFO. It drains one result per cycle onto the register file's single write port (`we`/`wreg`/`wdata`). Decode can keep reading the register file while writes are pending, because the block forwards pending values for two read-port addresses.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: producer offers a result.
- `in_ready` output 1: queue can accept.
- `in_reg` input 5: destination register.
- `in_data` input 32: result value.
- `hold` input 1: suppresses draining.
- `we` output 1: register-file write enable (registered).
- `wreg` output 5: register-file write address (registered).
- `wdata` output 32: register-file write data (registered).
- `rreg1`, `rreg2` input 5: decode read addresses.
- `fwd1_hit`, `fwd2_hit` output 1: a pending write exists for `rreg1`/`rreg2`.
- `fwd1_data`, `fwd2_data` output 32: youngest pending value for `rreg1`/`rreg2`.
- `count` output CW: number of occupied FIFO entries.
- `empty`, `full` output 1: `count==0`, `count==DEPTH`.

## Operation
- Accept handshake:
  - `in_ready = !full`, combinational from `count`; it does not depend on a same-cycle pop.
  - A transfer occurs at a rising edge when `in_valid && in_ready`.
  - Accepted entries with `in_reg==0` complete the handshake but are discarded (no enqueue, `count` unchanged).
- FIFO storage:
  - Circular buffer with head/tail pointers of `$clog2(DEPTH)` bits; pointers wrap modulo DEPTH.
  - `count` tracks occupancy.
- Drain: at each rising edge with `!empty && !hold`, the head entry pops and loads the output stage: `we<=1`, `wreg<=head.reg`, `wdata<=head.data`.
  - Otherwise `we<=0`; `wreg`/`wdata` hold their last value.
  - `we` is high for exactly one cycle per drained entry.
- Simultaneous push and pop: both occur and `count` is unchanged.
  - When full, push is blocked even if a pop occurs that edge.
  - When empty, an entry pushed at edge N cannot pop at edge N.
- Forwarding for port k (combinational):
  - `rreg_k==0`: `fwd_k_hit=0`, `fwd_k_data=0`.
  - Otherwise, search valid FIFO entries from youngest (tail-1) to oldest (head). The first entry with a matching register wins.
  - If no FIFO entry matches and `we && wreg==rreg_k`, the output stage hits.
  - No match: `fwd_k_hit=0`, `fwd_k_data=0`.
- Ordering: writes reach the register file in acceptance order. Multiple pending writes to one register are all drained; forwarding always returns the youngest.

## Timing
- Reset values: `count=0`, `empty=1`, `full=0`, `in_ready=1`, `we=0`, `wreg=0`, `wdata=0`, `fwd*_hit=0`, `fwd*_data=0`; head=tail=0.
- Reset asserted mid-operation discards all pending entries. `we` drops asynchronously; no partial write is emitted after reset.
- Latency, push at edge N into an empty queue with `hold` low:
  - edge N+1: pop; `we` high during cycle N+1.
  - edge N+2: register file captures the write.
- `fwd_hit` covers the entry from the cycle after edge N through cycle N+1. `fwd_hit` is therefore continuous until the register file holds the value.
- Throughput: one accept and one drain per cycle sustained. A full queue draining continuously accepts one entry per cycle after each pop frees a slot, with `in_ready` high the cycle after the pop.
- `hold` sampled high at edge M: no pop at M, and `we` is low in the cycle after M.

## Test plan
- Reset then single write: push (r5, 0x1234) at edge 1 → `we=1`, `wreg=5`, `wdata=0x1234` in cycle 2 only. `fwd1_hit=1` with `rreg1=5` in cycles 1–2, and 0 in cycle 3.
- Fill/full: with `hold=1`, push 4 entries → `count=4`, `full=1`, `in_ready=0`. A 5th `in_valid` is not accepted. Release `hold` → four one-cycle `we` pulses in push order, then `empty=1`.
- Youngest-wins forwarding: push (r7, 0xA) then (r7, 0xB) with `hold=1` → `fwd2_data=0xB`. After the drains, the register-file write order is 0xA then 0xB.
- Zero register: push (r0, 0xFFFF) → handshake completes, `count` stays 0, no `we`. `rreg1=0` → `fwd1_hit=0`.
- Simultaneous push/pop with `count=2` → `count` stays 2. Pointer wrap-around is exercised over more than 8 cycles of continuous traffic with no lost or duplicated writes.
- Async reset mid-drain: assert `rst_n=0` between edges with `count=3` and `we=1` → `we=0` immediately and `count=0`. No writes occur after reset release until new pushes.

Source files
------------

// File: rtl/wb_queue.sv
`default_nettype none
// wb_queue: in-order write-back FIFO feeding the register-file write port,
// with youngest-wins forwarding of pending writes to two read ports.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_reg,
  input  logic [31:0]   in_data,
  input  logic          hold,
  output logic          we,
  output logic [4:0]    wreg,
  output logic [31:0]   wdata,
  input  logic [4:0]    rreg1,
  input  logic [4:0]    rreg2,
  output logic          fwd1_hit,
  output logic          fwd2_hit,
  output logic [31:0]   fwd1_data,
  output logic [31:0]   fwd2_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign push = in_valid && in_ready && (in_reg != 5'd0);
  assign pop  = !empty && !hold;

  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[tail]  <= in_reg;
      data_mem[tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      we    <= 1'b0;
      wreg  <= 5'd0;
      wdata <= 32'd0;
    end else begin
      we <= pop;
      if (pop) begin
        wreg  <= reg_mem[head];
        wdata <= data_mem[head];
        head  <= head + AW'(1);
      end
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  generate
    for (genvar k = 0; k < 2; k++) begin : g_fwd
      logic [4:0]  rr;
      logic        hit;
      logic [31:0] data;

      assign rr = (k == 0) ? rreg1 : rreg2;

      // Scan oldest to youngest so the youngest match overwrites earlier ones;
      // the output stage is older than every FIFO entry, so it goes first.
      always_comb begin
        hit  = 1'b0;
        data = 32'd0;
        if (rr != 5'd0) begin
          if (we && (wreg == rr)) begin
            hit  = 1'b1;
            data = wdata;
          end
          for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (reg_mem[head + AW'(i)] == rr)) begin
              hit  = 1'b1;
              data = data_mem[head + AW'(i)];
            end
          end
        end
      end
    end
  endgenerate

  assign fwd1_hit  = g_fwd[0].hit;
  assign fwd1_data = g_fwd[0].data;
  assign fwd2_hit  = g_fwd[1].hit;
  assign fwd2_data = g_fwd[1].data;

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// tb_wb_queue: directed self-checking bench for wb_queue (DEPTH=4).
module tb_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        hold;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [4:0]  rreg1;
  logic [4:0]  rreg2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int tests_run = 0;
  int fails     = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .hold(hold), .we(we), .wreg(wreg), .wdata(wdata),
    .rreg1(rreg1), .rreg2(rreg2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0;
    hold = 1'b0; rreg1 = 5'd5; rreg2 = 5'd7;
    #2;
    tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests_run++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests_run++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", we); end
    tests_run++; if (wreg !== 5'd0 || wdata !== 32'd0) begin fails++; $display("FAIL reset_wport got %0d/%h exp 0/0", wreg, wdata); end
    tests_run++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin fails++; $display("FAIL reset_fwd1 got %b/%h exp 0/0", fwd1_hit, fwd1_data); end
    tests_run++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin fails++; $display("FAIL reset_fwd2 got %b/%h exp 0/0", fwd2_hit, fwd2_data); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    rreg1 = 5'd5;
    in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h1234;
    tick();  // edge 1: push
    in_valid = 1'b0;
    tests_run++; if (we !== 1'b0) begin fails++; $display("FAIL single_c1_we got %b exp 0", we); end
    tests_run++; if (count !== 3'd1) begin fails++; $display("FAIL single_c1_count got %0d exp 1", count); end
    tests_run++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h1234) begin fails++; $display("FAIL single_c1_fwd got %b/%h exp 1/1234", fwd1_hit, fwd1_data); end
    tick();  // edge 2: pop
    tests_run++; if (we !== 1'b1 || wreg !== 5'd5 || wdata !== 32'h1234) begin fails++; $display("FAIL single_c2_write got %b/%0d/%h exp 1/5/1234", we, wreg, wdata); end
    tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL single_c2_count got %0d exp 0", count); end
    tests_run++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h1234) begin fails++; $display("FAIL single_c2_fwd got %b/%h exp 1/1234", fwd1_hit, fwd1_data); end
    tick();
    tests_run++; if (we !== 1'b0) begin fails++; $display("FAIL single_c3_we got %b exp 0", we); end
    tests_run++; if (wreg !== 5'd5 || wdata !== 32'h1234) begin fails++; $display("FAIL single_c3_hold_wport got %0d/%h exp 5/1234", wreg, wdata); end
    tests_run++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin fails++; $display("FAIL single_c3_fwd got %b/%h exp 0/0", fwd1_hit, fwd1_data); end
  endtask

  task automatic test_fill();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(i + 1); in_data = 32'h100 + 32'(i);
      tick();
      tests_run++; if (count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count%0d got %0d exp %0d", i, count, i + 1); end
    end
    tests_run++; if (full !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL fill_full got full=%b rdy=%b exp 1/0", full, in_ready); end
    in_reg = 5'd9; in_data = 32'h999;
    tick();
    tests_run++; if (count !== 3'd4 || we !== 1'b0) begin fails++; $display("FAIL fill_blocked got cnt=%0d we=%b exp 4/0", count, we); end
    in_valid = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (we !== 1'b1 || wreg !== 5'(i + 1) || wdata !== 32'h100 + 32'(i)) begin fails++; $display("FAIL fill_drain%0d got %b/%0d/%h exp 1/%0d/%h", i, we, wreg, wdata, i + 1, 32'h100 + 32'(i)); end
    end
    tests_run++; if (empty !== 1'b1) begin fails++; $display("FAIL fill_empty got %b exp 1", empty); end
    tick();
    tests_run++; if (we !== 1'b0) begin fails++; $display("FAIL fill_idle_we got %b exp 0", we); end
  endtask

  task automatic test_full_stream();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(i + 1); in_data = 32'h200 + 32'(i);
      tick();
    end
    hold = 1'b0; in_reg = 5'd20; in_data = 32'h2020;
    tick();  // full at edge: pop only
    tests_run++; if (count !== 3'd3 || in_ready !== 1'b1 || wreg !== 5'd1) begin fails++; $display("FAIL stream_first got cnt=%0d rdy=%b wreg=%0d exp 3/1/1", count, in_ready, wreg); end
    tick();  // push and pop
    in_valid = 1'b0;
    tests_run++; if (count !== 3'd3 || we !== 1'b1 || wreg !== 5'd2) begin fails++; $display("FAIL stream_second got cnt=%0d we=%b wreg=%0d exp 3/1/2", count, we, wreg); end
    tick(); tick(); tick();
    tests_run++; if (we !== 1'b1 || wreg !== 5'd20 || wdata !== 32'h2020 || empty !== 1'b1) begin fails++; $display("FAIL stream_last got %b/%0d/%h e=%b exp 1/20/2020/1", we, wreg, wdata, empty); end
    tick();
  endtask

  task automatic test_youngest();
    hold = 1'b1; rreg2 = 5'd7;
    in_valid = 1'b1; in_reg = 5'd7; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    tests_run++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'hB) begin fails++; $display("FAIL young_fwd got %b/%h exp 1/b", fwd2_hit, fwd2_data); end
    hold = 1'b0;
    tick();
    tests_run++; if (we !== 1'b1 || wreg !== 5'd7 || wdata !== 32'hA) begin fails++; $display("FAIL young_wr1 got %b/%0d/%h exp 1/7/a", we, wreg, wdata); end
    tests_run++; if (fwd2_data !== 32'hB) begin fails++; $display("FAIL young_fwd_mid got %h exp b", fwd2_data); end
    tick();
    tests_run++; if (we !== 1'b1 || wdata !== 32'hB) begin fails++; $display("FAIL young_wr2 got %b/%h exp 1/b", we, wdata); end
    tick();
    tests_run++; if (we !== 1'b0 || fwd2_hit !== 1'b0) begin fails++; $display("FAIL young_done got we=%b hit=%b exp 0/0", we, fwd2_hit); end
  endtask

  task automatic test_zero();
    rreg1 = 5'd0;
    in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (count !== 3'd0 || fwd1_hit !== 1'b0) begin fails++; $display("FAIL zero_count got cnt=%0d hit=%b exp 0/0", count, fwd1_hit); end
    tick();
    tests_run++; if (we !== 1'b0) begin fails++; $display("FAIL zero_we got %b exp 0", we); end
  endtask

  task automatic test_back_to_back();
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'h5000 + 32'(10 + i);
      tick();
    end
    hold = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_reg = 5'(12 + k); in_data = 32'h5000 + 32'(12 + k);
      tick();
      tests_run++; if (count !== 3'd2 || we !== 1'b1 || wreg !== 5'(10 + k) || wdata !== 32'h5000 + 32'(10 + k)) begin fails++; $display("FAIL b2b_%0d got cnt=%0d %b/%0d/%h exp 2/1/%0d", k, count, we, wreg, wdata, 10 + k); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++; if (we !== 1'b1 || wreg !== 5'(20 + k) || wdata !== 32'h5000 + 32'(20 + k)) begin fails++; $display("FAIL b2b_tail%0d got %b/%0d/%h exp 1/%0d", k, we, wreg, wdata, 20 + k); end
    end
    tick();
    tests_run++; if (we !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL b2b_end got we=%b e=%b exp 0/1", we, empty); end
  endtask

  task automatic test_async_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(i + 1); in_data = 32'h300 + 32'(i);
      tick();
    end
    in_valid = 1'b0; hold = 1'b0;
    tick();
    tests_run++; if (count !== 3'd3 || we !== 1'b1) begin fails++; $display("FAIL arst_pre got cnt=%0d we=%b exp 3/1", count, we); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (we !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL arst_now got we=%b cnt=%0d exp 0/0", we, count); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (we !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL arst_post%0d got we=%b cnt=%0d exp 0/0", i, we, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_stream();
    test_youngest();
    test_zero();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
